// File: rtl/seed_random_2_deck_dealer_if.sv
// rtl/seed_random_2_deck_dealer_if.sv - deal request/response bundle between game FSM and deck dealer
interface seed_random_2_deck_dealer_if;
   logic [7:0] seed_i;
   logic       deal_req_i;
   logic       new_deck_i;
   logic       card_valid_o;
   logic [5:0] card_index_o;
   logic [3:0] card_rank_o;
   logic [1:0] card_suit_o;
   logic [3:0] card_points_o;
   logic [5:0] cards_left_o;
   logic       deck_empty_o;
   logic       busy_o;

   modport master (
      output seed_i, deal_req_i, new_deck_i,
      input  card_valid_o, card_index_o, card_rank_o, card_suit_o, card_points_o,
             cards_left_o, deck_empty_o, busy_o
   );

   modport slave (
      input  seed_i, deal_req_i, new_deck_i,
      output card_valid_o, card_index_o, card_rank_o, card_suit_o, card_points_o,
             cards_left_o, deck_empty_o, busy_o
   );
endinterface

// File: rtl/seed_random_2_deck_dealer.sv
// rtl/seed_random_2_deck_dealer.sv - seeded card dealer with used-mask linear probing
module seed_random_2_deck_dealer #(
   parameter int DECK_SIZE  = 52,
   parameter int SUIT_SIZE  = 13,
   parameter int ACE_POINTS = 11
) (
   input  logic                          clk_dp_c_i,
   input  logic                          rst_dp_c_i,
   seed_random_2_deck_dealer_if.slave    dealer
);
   typedef enum logic [1:0] {IDLE = 2'd0, PROBE = 2'd1, DONE = 2'd2} state_t;

   localparam logic [7:0] SEED_MOD   = 8'(DECK_SIZE);
   localparam logic [5:0] LAST_IDX   = 6'(DECK_SIZE - 1);
   localparam logic [5:0] FULL_COUNT = 6'(DECK_SIZE);
   localparam logic [5:0] SUIT_W     = 6'(SUIT_SIZE);
   localparam logic [3:0] ACE_W      = 4'(ACE_POINTS);

   state_t               state_q, state_d;
   logic [DECK_SIZE-1:0] used_q, used_d;
   logic [5:0]           probe_idx_q, probe_idx_d;
   logic [5:0]           cards_left_q, cards_left_d;
   logic [5:0]           card_index_q, card_index_d;
   logic [3:0]           card_rank_q, card_rank_d;
   logic [1:0]           card_suit_q, card_suit_d;
   logic [3:0]           card_points_q, card_points_d;

   logic [5:0]           seed_idx;
   logic [1:0]           dec_suit;
   logic [3:0]           dec_rank;
   logic [3:0]           dec_points;
   logic                 deck_empty;

   assign seed_idx   = 6'(dealer.seed_i % SEED_MOD);
   assign deck_empty = (cards_left_q == 6'd0);

   // Decode always follows the slot being probed so the mark cycle can register it directly.
   assign dec_suit   = 2'(probe_idx_q / SUIT_W);
   assign dec_rank   = 4'(probe_idx_q % SUIT_W) + 4'd1;
   assign dec_points = (dec_rank == 4'd1) ? ACE_W :
                       (dec_rank > 4'd10) ? 4'd10 : dec_rank;

   always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
      if (!rst_dp_c_i) begin
         state_q       <= IDLE;
         used_q        <= '0;
         probe_idx_q   <= 6'd0;
         cards_left_q  <= FULL_COUNT;
         card_index_q  <= 6'd0;
         card_rank_q   <= 4'd0;
         card_suit_q   <= 2'd0;
         card_points_q <= 4'd0;
      end else begin
         state_q       <= state_d;
         used_q        <= used_d;
         probe_idx_q   <= probe_idx_d;
         cards_left_q  <= cards_left_d;
         card_index_q  <= card_index_d;
         card_rank_q   <= card_rank_d;
         card_suit_q   <= card_suit_d;
         card_points_q <= card_points_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      used_d        = used_q;
      probe_idx_d   = probe_idx_q;
      cards_left_d  = cards_left_q;
      card_index_d  = card_index_q;
      card_rank_d   = card_rank_q;
      card_suit_d   = card_suit_q;
      card_points_d = card_points_q;

      if (dealer.new_deck_i) begin
         state_d       = IDLE;
         used_d        = '0;
         cards_left_d  = FULL_COUNT;
         card_index_d  = 6'd0;
         card_rank_d   = 4'd0;
         card_suit_d   = 2'd0;
         card_points_d = 4'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (dealer.deal_req_i && !deck_empty) begin
                  probe_idx_d = seed_idx;
                  state_d     = PROBE;
               end
            end
            // PROBE is only entered with a free slot somewhere, so the scan always ends.
            PROBE: begin
               if (!used_q[probe_idx_q]) begin
                  used_d[probe_idx_q] = 1'b1;
                  cards_left_d        = cards_left_q - 6'd1;
                  card_index_d        = probe_idx_q;
                  card_rank_d         = dec_rank;
                  card_suit_d         = dec_suit;
                  card_points_d       = dec_points;
                  state_d             = DONE;
               end else begin
                  probe_idx_d = (probe_idx_q == LAST_IDX) ? 6'd0 : probe_idx_q + 6'd1;
               end
            end
            DONE: begin
               if (!dealer.deal_req_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign dealer.card_valid_o  = (state_q == DONE);
   assign dealer.busy_o        = (state_q == PROBE);
   assign dealer.card_index_o  = card_index_q;
   assign dealer.card_rank_o   = card_rank_q;
   assign dealer.card_suit_o   = card_suit_q;
   assign dealer.card_points_o = card_points_q;
   assign dealer.cards_left_o  = cards_left_q;
   assign dealer.deck_empty_o  = deck_empty;
endmodule
